// File: rtl/switch_rate_select.sv
// Push-button front end for the LED blink block: synchronise, debounce, classify
// presses as short or long, and maintain the 2-bit blink-rate index.
module switch_rate_select #(
  parameter int g_debounce_limit   = 250000,
  parameter int g_long_press_limit = 25000000,
  parameter int g_num_rates        = 4
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Switch_1,
  output logic       o_Switch_Clean,
  output logic       o_Press_Pulse,
  output logic       o_Long_Press,
  output logic [1:0] o_Rate_Sel,
  output logic       o_Rate_Changed
);

  typedef enum logic [1:0] {
    IDLE,
    PRESSED,
    LONG_HELD
  } state_t;

  localparam logic [31:0] c_db_last   = 32'(g_debounce_limit - 1);
  localparam logic [31:0] c_hold_last = 32'(g_long_press_limit - 1);
  localparam logic [1:0]  c_rate_last = 2'(g_num_rates - 1);

  logic        r_sync1, r_sync2;
  logic [31:0] r_db_cnt;
  logic        r_clean, r_clean_d;
  state_t      r_state, w_state_next;
  logic [31:0] r_hold, w_hold_next;
  logic [1:0]  r_rate, w_rate_next;
  logic        r_press, w_press_next;
  logic        r_long, w_long_next;
  logic        r_changed;
  logic        w_rise, w_fall;

  // Two-flop synchroniser, then a debouncer that only moves the clean level
  // after g_debounce_limit consecutive disagreeing samples.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_db_cnt  <= '0;
      r_clean   <= 1'b0;
      r_clean_d <= 1'b0;
    end else begin
      r_sync1   <= i_Switch_1;
      r_sync2   <= r_sync1;
      r_clean_d <= r_clean;
      if (r_sync2 == r_clean) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == c_db_last) begin
        r_clean  <= r_sync2;
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + 32'd1;
      end
    end
  end

  assign w_rise = r_clean & ~r_clean_d;
  assign w_fall = ~r_clean & r_clean_d;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) r_state <= IDLE;
    else          r_state <= w_state_next;
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:      if (w_rise) w_state_next = PRESSED;
      PRESSED: begin
        if (w_fall)                     w_state_next = IDLE;
        else if (r_hold == c_hold_last) w_state_next = LONG_HELD;
      end
      LONG_HELD: if (w_fall) w_state_next = IDLE;
      default:   w_state_next = IDLE;
    endcase
  end

  // A release in the threshold cycle wins: it is taken as a short press.
  always_comb begin
    w_hold_next  = r_hold;
    w_rate_next  = r_rate;
    w_press_next = 1'b0;
    w_long_next  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_rise) begin
          w_press_next = 1'b1;
          w_hold_next  = '0;
        end
      end
      PRESSED: begin
        if (w_fall) begin
          w_rate_next = (r_rate == c_rate_last) ? 2'd0 : 2'(r_rate + 2'd1);
        end else if (r_hold == c_hold_last) begin
          w_long_next = 1'b1;
          w_rate_next = 2'd0;
        end else begin
          w_hold_next = r_hold + 32'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_hold    <= '0;
      r_rate    <= 2'd0;
      r_press   <= 1'b0;
      r_long    <= 1'b0;
      r_changed <= 1'b0;
    end else begin
      r_hold    <= w_hold_next;
      r_rate    <= w_rate_next;
      r_press   <= w_press_next;
      r_long    <= w_long_next;
      r_changed <= (w_rate_next != r_rate);
    end
  end

  assign o_Switch_Clean = r_clean;
  assign o_Press_Pulse  = r_press;
  assign o_Long_Press   = r_long;
  assign o_Rate_Sel     = r_rate;
  assign o_Rate_Changed = r_changed;

endmodule

// File: tb/tb_switch_rate_select.sv
// Directed bench for switch_rate_select with short debounce/long-press limits;
// cycle numbers count from the first edge that samples a new button level.
module tb_switch_rate_select;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sw;
  logic       clean, press, long_p, rc;
  logic [1:0] rate;

  int n_checks = 0;
  int n_fail   = 0;

  // Observations from the last run_press call.
  int n_press, n_long, n_rc;
  int c_press, c_long, c_rc, c_clean;
  int last_rate;

  switch_rate_select #(
    .g_debounce_limit  (4),
    .g_long_press_limit(20),
    .g_num_rates       (4)
  ) dut (
    .i_Clk         (clk),
    .i_Rst_L       (rst_n),
    .i_Switch_1    (sw),
    .o_Switch_Clean(clean),
    .o_Press_Pulse (press),
    .o_Long_Press  (long_p),
    .o_Rate_Sel    (rate),
    .o_Rate_Changed(rc)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    sw    = 1'b0;
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();
  endtask

  // Hold the button for n_high cycles, release, and watch n_tail more cycles.
  task automatic run_press(input int n_high, input int n_tail);
    n_press = 0; n_long = 0; n_rc = 0;
    c_press = -1; c_long = -1; c_rc = -1; c_clean = -1;
    sw = 1'b1;
    for (int cyc = 1; cyc <= n_high + n_tail; cyc++) begin
      tick();
      if (press)  begin n_press++; c_press = cyc; end
      if (long_p) begin n_long++;  c_long  = cyc; end
      if (rc)     begin n_rc++;    c_rc    = cyc; end
      if (clean && c_clean < 0) c_clean = cyc;
      last_rate = int'(rate);
      if (cyc == n_high) sw = 1'b0;
    end
  endtask

  task automatic test_reset();
    sw    = 1'b1;
    rst_n = 1'b0;
    repeat (10) tick();
    n_checks++;
    if ({clean, press, long_p, rc, rate} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected 000000", {clean, press, long_p, rc, rate});
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      n_checks++;
      if (clean !== (k >= 6)) begin
        n_fail++;
        $display("FAIL reset_release_clean cycle %0d: got %b expected %b", k, clean, (k >= 6));
      end
      n_checks++;
      if (press !== (k == 7)) begin
        n_fail++;
        $display("FAIL reset_release_press cycle %0d: got %b expected %b", k, press, (k == 7));
      end
    end
    sw = 1'b0;
    repeat (20) tick();
  endtask

  task automatic test_bounce();
    int seen_clean;
    int seen_pulse;
    apply_reset();
    seen_clean = 0;
    seen_pulse = 0;
    for (int r = 0; r < 5; r++) begin
      for (int k = 0; k < 4; k++) begin
        sw = (k < 3);
        tick();
        if (clean) seen_clean++;
        if (press || long_p || rc) seen_pulse++;
      end
    end
    sw = 1'b0;
    repeat (10) begin
      tick();
      if (clean) seen_clean++;
      if (press || long_p || rc) seen_pulse++;
    end
    n_checks++;
    if (seen_clean !== 0) begin
      n_fail++;
      $display("FAIL bounce_clean: got %0d high cycles expected 0", seen_clean);
    end
    n_checks++;
    if (seen_pulse !== 0 || rate !== 2'd0) begin
      n_fail++;
      $display("FAIL bounce_pulses: got %0d pulses rate %0d expected 0 pulses rate 0", seen_pulse, rate);
    end
  endtask

  task automatic test_short_wrap();
    int exp_rate [4] = '{1, 2, 3, 0};
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      run_press(10, 12);
      n_checks++;
      if (last_rate !== exp_rate[i]) begin
        n_fail++;
        $display("FAIL short_rate press %0d: got %0d expected %0d", i, last_rate, exp_rate[i]);
      end
      n_checks++;
      if (n_rc !== 1 || c_rc !== 17) begin
        n_fail++;
        $display("FAIL short_changed press %0d: got %0d pulses at %0d expected 1 at 17", i, n_rc, c_rc);
      end
      n_checks++;
      if (n_press !== 1 || c_press !== 7 || c_clean !== 6 || n_long !== 0) begin
        n_fail++;
        $display("FAIL short_timing press %0d: got press %0d@%0d clean@%0d long %0d expected 1@7 clean@6 long 0",
                 i, n_press, c_press, c_clean, n_long);
      end
    end
  endtask

  task automatic test_long_at_2();
    apply_reset();
    run_press(10, 12);
    run_press(10, 12);
    n_checks++;
    if (last_rate !== 2) begin
      n_fail++;
      $display("FAIL long2_setup: got rate %0d expected 2", last_rate);
    end
    run_press(40, 15);
    n_checks++;
    if (n_long !== 1 || c_long !== 27 || c_press !== 7) begin
      n_fail++;
      $display("FAIL long2_pulse: got %0d@%0d press@%0d expected 1@27 press@7", n_long, c_long, c_press);
    end
    n_checks++;
    if (n_rc !== 1 || c_rc !== 27 || last_rate !== 0) begin
      n_fail++;
      $display("FAIL long2_rate: got changed %0d@%0d rate %0d expected 1@27 rate 0", n_rc, c_rc, last_rate);
    end
  endtask

  task automatic test_long_at_0();
    apply_reset();
    run_press(40, 15);
    n_checks++;
    if (n_long !== 1 || c_long !== 27) begin
      n_fail++;
      $display("FAIL long0_pulse: got %0d@%0d expected 1@27", n_long, c_long);
    end
    n_checks++;
    if (n_rc !== 0 || last_rate !== 0) begin
      n_fail++;
      $display("FAIL long0_rate: got changed %0d rate %0d expected 0 rate 0", n_rc, last_rate);
    end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    // Release lands in the threshold cycle: short press wins.
    run_press(20, 15);
    n_checks++;
    if (n_long !== 0 || last_rate !== 1 || n_rc !== 1 || c_rc !== 27) begin
      n_fail++;
      $display("FAIL simul_short: got long %0d rate %0d changed %0d@%0d expected 0 1 1@27",
               n_long, last_rate, n_rc, c_rc);
    end
    // One cycle longer: the threshold is reached first.
    run_press(21, 15);
    n_checks++;
    if (n_long !== 1 || c_long !== 27 || last_rate !== 0 || n_rc !== 1 || c_rc !== 27) begin
      n_fail++;
      $display("FAIL simul_long: got long %0d@%0d rate %0d changed %0d@%0d expected 1@27 0 1@27",
               n_long, c_long, last_rate, n_rc, c_rc);
    end
  endtask

  task automatic test_reset_mid_press();
    int np, cp, other;
    apply_reset();
    repeat (3) run_press(10, 12);
    n_checks++;
    if (last_rate !== 3) begin
      n_fail++;
      $display("FAIL midreset_setup: got rate %0d expected 3", last_rate);
    end
    sw = 1'b1;
    repeat (17) tick();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({clean, press, long_p, rc, rate} !== 6'b0) begin
      n_fail++;
      $display("FAIL midreset_async: got %b expected 000000", {clean, press, long_p, rc, rate});
    end
    repeat (3) tick();
    rst_n = 1'b1;
    np = 0; cp = -1; other = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (press) begin np++; cp = k; end
      if (long_p || rc) other++;
    end
    n_checks++;
    if (np !== 1 || cp !== 7 || other !== 0) begin
      n_fail++;
      $display("FAIL midreset_repress: got %0d@%0d other %0d expected 1@7 other 0", np, cp, other);
    end
    sw = 1'b0;
    repeat (20) tick();
  endtask

  initial begin
    sw    = 1'b0;
    rst_n = 1'b0;
    test_reset();
    test_bounce();
    test_short_wrap();
    test_long_at_2();
    test_long_at_0();
    test_simultaneous();
    test_reset_mid_press();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/switch_rate_select.md
# switch_rate_select

Upstream control stage for the LED blink block. It synchronises and debounces one push-button and classifies each press as short or long. It keeps a 2-bit blink-rate index (0=10 Hz, 1=5 Hz, 2=2 Hz, 3=1 Hz) that the blink stage uses to choose its active LED/counter. A short press advances the index; a long press returns it to 0.

## Interface
- g_debounce_limit, 250000, consecutive cycles the synchronised input must differ from the clean level before the clean level changes (10 ms at 25 MHz); legal range ≥1.
- g_long_press_limit, 25000000, cycles the clean level must stay high before a press counts as long (1 s at 25 MHz); legal range ≥1.
- g_num_rates, 4, number of rate indices; index wraps from g_num_rates-1 to 0; legal range 1..4.
- i_Clk  input  1  system clock; the only clock.
- i_Rst_L  input  1  asynchronous active-low reset.
- i_Switch_1  input  1  raw button, asynchronous, 1 = pressed.
- o_Switch_Clean  output  1  debounced button level.
- o_Press_Pulse  output  1  one-cycle pulse on the clean rising edge.
- o_Long_Press  output  1  one-cycle pulse when the long-press threshold is reached.
- o_Rate_Sel  output  2  current rate index.
- o_Rate_Changed  output  1  one-cycle pulse on any cycle where o_Rate_Sel changes value.

## Operation
- Reset: while i_Rst_L=0, all flops clear asynchronously. Reset values: o_Switch_Clean=0, all pulses=0, o_Rate_Sel=0, state=IDLE, counters=0. Release is sampled on i_Clk.
- Synchroniser: two flops on i_Switch_1; the downstream logic uses only the second flop (sync).
- Debounce counter (32 bit):
  - Clears on any cycle where sync == o_Switch_Clean.
  - Otherwise increments.
  - When the counter equals g_debounce_limit-1 and sync still differs, o_Switch_Clean takes sync on the next edge and the counter clears.
  - Any bounce, i.e. sync returning to the clean level, restarts the count.
- FSM states: IDLE, PRESSED, LONG_HELD.
  - IDLE: a clean rising edge moves to PRESSED, pulses o_Press_Pulse and clears the hold counter.
  - PRESSED: the hold counter increments each cycle.
    - Clean falling edge: go to IDLE and advance the index (short press).
    - Otherwise, when the hold counter equals g_long_press_limit-1: go to LONG_HELD, pulse o_Long_Press and set the index to 0.
  - LONG_HELD: a clean falling edge goes to IDLE with no index change.
- Index update: short press gives index = (index == g_num_rates-1) ? 0 : index+1.
  - o_Rate_Changed pulses only if the value actually differs. A long press at index 0 gives no pulse; g_num_rates=1 never pulses.
- Simultaneous events: a falling edge in the same cycle as the long threshold is treated as a short press and no o_Long_Press is issued.
- Reset mid-press: the press is discarded and no pulses occur after reset release. If the button is still held, the debouncer re-qualifies it and a fresh press is detected.
- Hold counter stops in LONG_HELD, so no wrap occurs on arbitrarily long holds.

## Timing
- Edges are counted from the i_Clk edge that first samples the new i_Switch_1 level into sync flop 1.
- i_Switch_1 to o_Switch_Clean: 2 + g_debounce_limit cycles for a bounce-free transition.
- o_Press_Pulse: asserted the cycle after o_Switch_Clean rises; high exactly 1 cycle.
- Short release: o_Rate_Sel updates and o_Rate_Changed pulses the cycle after o_Switch_Clean falls.
- Long press:
  - o_Long_Press, o_Rate_Sel=0 and o_Rate_Changed (if any) appear together, g_long_press_limit cycles after o_Press_Pulse.
  - The release of a long press produces no output activity except o_Switch_Clean falling.
- All outputs are registered; there are no combinational paths from i_Switch_1.

## Test plan
Use g_debounce_limit=4, g_long_press_limit=20, g_num_rates=4.
- Reset: hold i_Rst_L=0 with i_Switch_1=1 for 10 cycles -> all outputs 0; after release, o_Switch_Clean rises at cycle 6 and o_Press_Pulse follows 1 cycle later.
- Bounce: toggle i_Switch_1 high 3 cycles / low 1 cycle, repeated 5 times, then low -> o_Switch_Clean stays 0 and no pulses occur.
- Short-press wrap: four presses held 10 cycles each -> o_Rate_Sel goes 1, 2, 3, 0, with o_Rate_Changed pulsing once per release.
- Long press at index 2: hold 40 cycles -> o_Long_Press and o_Rate_Changed pulse together 20 cycles after o_Press_Pulse with o_Rate_Sel=0; release gives no further pulse.
- Long press at index 0 -> o_Long_Press pulses, o_Rate_Changed stays 0; separately, a release coinciding with the threshold -> index advances by 1 and no o_Long_Press.
- Reset mid-press: assert i_Rst_L at hold count 10 with index 3 -> o_Rate_Sel=0 immediately (asynchronous); after release with the button still held, a fresh o_Press_Pulse occurs at cycle 7.
